// File: rtl/traffic_pkg.sv
// Shared types, request bit indices and phase helpers for the intersection
// phase arbiter.
package traffic_pkg;

  localparam int NUM_REQ  = 5;
  localparam int NUM_CAND = 5;

  localparam int REQ_E_STR  = 0;
  localparam int REQ_E_LEFT = 1;
  localparam int REQ_W_STR  = 2;
  localparam int REQ_W_LEFT = 3;
  localparam int REQ_NS     = 4;

  typedef enum logic [2:0] {
    PH_NONE    = 3'd0,
    PH_E       = 3'd1,
    PH_W       = 3'd2,
    PH_EW_STR  = 3'd3,
    PH_EW_LEFT = 3'd4,
    PH_NS      = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  // Request bits released when a phase completes.
  function automatic logic [NUM_REQ-1:0] phase_mask(input phase_e p);
    case (p)
      PH_E:       phase_mask = 5'b00011;
      PH_W:       phase_mask = 5'b01100;
      PH_EW_STR:  phase_mask = 5'b00101;
      PH_EW_LEFT: phase_mask = 5'b01010;
      PH_NS:      phase_mask = 5'b10000;
      default:    phase_mask = 5'b00000;
    endcase
  endfunction

  // Round-robin candidate index <-> phase code.
  function automatic logic [2:0] phase_to_k(input phase_e p);
    case (p)
      PH_EW_STR:  phase_to_k = 3'd0;
      PH_EW_LEFT: phase_to_k = 3'd1;
      PH_E:       phase_to_k = 3'd2;
      PH_W:       phase_to_k = 3'd3;
      default:    phase_to_k = 3'd4;
    endcase
  endfunction

  function automatic phase_e k_to_phase(input logic [2:0] k);
    case (k)
      3'd0:    k_to_phase = PH_EW_STR;
      3'd1:    k_to_phase = PH_EW_LEFT;
      3'd2:    k_to_phase = PH_E;
      3'd3:    k_to_phase = PH_W;
      3'd4:    k_to_phase = PH_NS;
      default: k_to_phase = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_phase_age_ctr.sv
// Saturating wait-age counter for one approach; urgent once it hits MAX_WAIT.
module phase_age_ctr #(
  parameter int MAX_WAIT = 31,
  parameter int AGE_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic urgent
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  always_comb begin
    age_d = age_q;
    if (clr) begin
      age_d = '0;
    end else if (inc && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign urgent = (age_q == AGE_MAX);

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Latches approach requests, ages them, picks a compatible phase (round-robin
// with starvation override) and offers it to the light sequencer.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int MAX_WAIT = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  output logic                grant_valid,
  input  logic                grant_ready,
  output logic [2:0]          grant_phase,
  input  logic                phase_done,
  output logic [NUM_REQ-1:0]  pending,
  output logic                serving
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  phase_e             grant_phase_q, grant_phase_d;
  logic               grant_valid_q, grant_valid_d;
  logic               serving_q, serving_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  clr_mask;
  logic [NUM_REQ-1:0]  active_mask;
  logic [NUM_REQ-1:0]  urgent;
  logic [NUM_CAND-1:0] elig;
  phase_e              sel_phase;
  logic                found;

  always_comb begin
    active_mask = (state_q == ST_SERVE) ? phase_mask(grant_phase_q) : '0;
    clr_mask    = (state_q == ST_SERVE && phase_done) ? active_mask : '0;
    // A fresh request on the clearing cycle keeps its bit set.
    pending_d   = (pending_q & ~clr_mask) | req;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_age
      phase_age_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .AGE_W    (AGE_W)
      ) u_age (
        .clk    (clk),
        .reset  (reset),
        .inc    (pending_q[gi] & ~active_mask[gi]),
        .clr    (~pending_d[gi]),
        .urgent (urgent[gi])
      );
    end
  endgenerate

  always_comb begin
    int sum;
    elig[0] = pending_q[REQ_E_STR]  & pending_q[REQ_W_STR];
    elig[1] = pending_q[REQ_E_LEFT] & pending_q[REQ_W_LEFT];
    elig[2] = pending_q[REQ_E_STR]  | pending_q[REQ_E_LEFT];
    elig[3] = pending_q[REQ_W_STR]  | pending_q[REQ_W_LEFT];
    elig[4] = pending_q[REQ_NS];

    sel_phase = PH_NONE;
    found     = 1'b0;
    sum       = 0;
    for (int off = 1; off <= NUM_CAND; off++) begin
      sum = int'(rr_ptr_q) + off;
      if (sum >= NUM_CAND) sum = sum - NUM_CAND;
      if (!found && elig[sum]) begin
        found     = 1'b1;
        sel_phase = k_to_phase(3'(sum));
      end
    end

    // Descending scan so the lowest-index starving approach has the last word.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (urgent[i]) begin
        if (i <= REQ_E_LEFT)      sel_phase = PH_E;
        else if (i <= REQ_W_LEFT) sel_phase = PH_W;
        else                      sel_phase = PH_NS;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_phase_d = grant_phase_q;
    grant_valid_d = grant_valid_q;
    serving_d     = serving_q;
    rr_ptr_d      = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          grant_phase_d = sel_phase;
          grant_valid_d = 1'b1;
          state_d       = ST_OFFER;
        end else begin
          grant_phase_d = PH_NONE;
        end
      end
      ST_OFFER: begin
        if (grant_ready) begin
          grant_valid_d = 1'b0;
          serving_d     = 1'b1;
          rr_ptr_d      = phase_to_k(grant_phase_q);
          state_d       = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (phase_done) begin
          serving_d     = 1'b0;
          grant_phase_d = PH_NONE;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_phase_d = PH_NONE;
        grant_valid_d = 1'b0;
        serving_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_phase_q <= PH_NONE;
      grant_valid_q <= 1'b0;
      serving_q     <= 1'b0;
      pending_q     <= '0;
      rr_ptr_q      <= 3'd4;
    end else begin
      state_q       <= state_d;
      grant_phase_q <= grant_phase_d;
      grant_valid_q <= grant_valid_d;
      serving_q     <= serving_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_phase = grant_phase_q;
  assign pending     = pending_q;
  assign serving     = serving_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: expected grant phases are queued as
// stimulus is applied and compared when each new offer appears.
module tb_traffic_phase_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req;
  logic       grant_ready;
  logic       phase_done;

  logic       a_gv, b_gv;
  logic [2:0] a_ph, b_ph;
  logic [4:0] a_pend, b_pend;
  logic       a_srv, b_srv;

  logic       use_mw;
  logic       gv, srv;
  logic [2:0] ph;
  logic [4:0] pend;

  int checks;
  int failures;
  int exp_q[$];
  logic gv_prev;

  always #5 clk = ~clk;

  traffic_phase_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant_valid (a_gv),
    .grant_ready (grant_ready),
    .grant_phase (a_ph),
    .phase_done  (phase_done),
    .pending     (a_pend),
    .serving     (a_srv)
  );

  traffic_phase_arbiter #(.MAX_WAIT(4)) dut_mw (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant_valid (b_gv),
    .grant_ready (grant_ready),
    .grant_phase (b_ph),
    .phase_done  (phase_done),
    .pending     (b_pend),
    .serving     (b_srv)
  );

  assign gv   = use_mw ? b_gv   : a_gv;
  assign ph   = use_mw ? b_ph   : a_ph;
  assign pend = use_mw ? b_pend : a_pend;
  assign srv  = use_mw ? b_srv  : a_srv;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rising offer is matched against the next queued phase.
  always @(posedge clk) begin
    #1;
    if (!reset && gv && !gv_prev) begin
      if (exp_q.size() == 0) chk("sb_unexpected_grant", int'(ph), 7);
      else                   chk("grant_phase", int'(ph), exp_q.pop_front());
    end
    gv_prev = reset ? 1'b0 : gv;
  end

  task automatic do_reset();
    reset       = 1'b1;
    req         = '0;
    grant_ready = 1'b0;
    phase_done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_req(input logic [4:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic wait_serving();
    int n;
    n = 0;
    while (!srv && n < 60) begin
      tick();
      n++;
    end
    if (!srv) chk("timeout_serving", 0, 1);
  endtask

  // Accept n offers, finishing each phase done_delay cycles after accept.
  task automatic serve_auto(input int n, input int done_delay);
    grant_ready = 1'b1;
    for (int g = 0; g < n; g++) begin
      wait_serving();
      repeat (done_delay - 1) tick();
      phase_done = 1'b1;
      tick();
      phase_done = 1'b0;
    end
    grant_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    gv_prev  = 1'b0;
    use_mw   = 1'b0;

    // Reset state and single E request with 2-cycle latency.
    do_reset();
    chk("rst_pending", int'(pend), 0);
    chk("rst_grant_valid", int'(gv), 0);
    chk("rst_grant_phase", int'(ph), 0);
    chk("rst_serving", int'(srv), 0);
    exp_q.push_back(1);
    pulse_req(5'b00001);
    chk("t1_pending", int'(pend), 1);
    chk("t1_gv_early", int'(gv), 0);
    tick();
    chk("t1_gv", int'(gv), 1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("t1_serving", int'(srv), 1);
    chk("t1_gv_serve", int'(gv), 0);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    chk("t1_pending_done", int'(pend), 0);
    chk("t1_serving_done", int'(srv), 0);
    chk("t1_phase_idle", int'(ph), 0);

    // All approaches at once: EW_STR, EW_LEFT, NS in round-robin order.
    do_reset();
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(5);
    pulse_req(5'b11111);
    serve_auto(3, 3);
    tick();
    tick();
    chk("t2_pending", int'(pend), 0);
    chk("t2_gv", int'(gv), 0);

    // Offer held stable while ready is low and requests toggle.
    do_reset();
    exp_q.push_back(5);
    exp_q.push_back(1);
    pulse_req(5'b10000);
    req = 5'b00011;
    tick();
    chk("t3_gv_c1", int'(gv), 1);
    chk("t3_ph_c1", int'(ph), 5);
    req = 5'b00000;
    tick();
    chk("t3_gv_c2", int'(gv), 1);
    chk("t3_ph_c2", int'(ph), 5);
    req = 5'b00010;
    tick();
    chk("t3_gv_c3", int'(gv), 1);
    chk("t3_ph_c3", int'(ph), 5);
    req = 5'b00000;
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("t3_serving", int'(srv), 1);
    chk("t3_ph_serve", int'(ph), 5);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    serve_auto(1, 2);
    chk("t3_pending_end", int'(pend), 0);

    // Starvation override with MAX_WAIT=4: e_left beats round-robin NS.
    use_mw = 1'b1;
    do_reset();
    exp_q.push_back(2);
    pulse_req(5'b00100);
    grant_ready = 1'b1;
    wait_serving();
    grant_ready = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(5);
    pulse_req(5'b10010);
    chk("t4_pending_wait", int'(pend), 5'b10110);
    repeat (6) tick();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    chk("t4_pending_after_w", int'(pend), 5'b10010);
    serve_auto(2, 2);
    chk("t4_pending_end", int'(pend), 0);
    use_mw = 1'b0;

    // Set beats clear when a request arrives on the done cycle.
    do_reset();
    exp_q.push_back(1);
    pulse_req(5'b00011);
    grant_ready = 1'b1;
    wait_serving();
    grant_ready = 1'b0;
    phase_done = 1'b1;
    req        = 5'b00001;
    tick();
    phase_done = 1'b0;
    req        = '0;
    chk("t5_pending_setwins", int'(pend), 5'b00001);
    exp_q.push_back(1);
    serve_auto(1, 2);
    chk("t5_pending_end", int'(pend), 0);

    // Reset during SERVE drops the grant; a new NS request is granted anew.
    do_reset();
    exp_q.push_back(5);
    pulse_req(5'b10000);
    grant_ready = 1'b1;
    wait_serving();
    grant_ready = 1'b0;
    chk("t6_pending_serve", int'(pend), 5'b10000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_gv_rst", int'(gv), 0);
    chk("t6_serving_rst", int'(srv), 0);
    chk("t6_pending_rst", int'(pend), 0);
    chk("t6_phase_rst", int'(ph), 0);
    exp_q.push_back(5);
    pulse_req(5'b10000);
    tick();
    chk("t6_gv_latency", int'(gv), 1);
    serve_auto(1, 2);

    tick();
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
Front-end scheduler for the intersection light sequencer. It latches transient sensor requests from five approaches and ages each waiting request. It picks one compatible signal phase by round-robin with a starvation override, then hands that phase to the light sequencer over a valid/ready grant handshake. It holds the grant until the sequencer reports the phase, including yellow, has finished.

Parameters:
MAX_WAIT, 31, cycles a pending request may wait before it becomes urgent (1..255)
AGE_W, $clog2(MAX_WAIT+1), width of each age counter (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req  in  5  raw sensor levels; bit0 e_str, bit1 e_left, bit2 w_str, bit3 w_left, bit4 ns
grant_valid  out  1  phase offer valid
grant_ready  in  1  sequencer accepts offered phase
grant_phase  out  3  offered/active phase code
phase_done  in  1  one-cycle pulse: sequencer finished the granted phase, yellow ended
pending  out  5  latched request mask (same bit order as req)
serving  out  1  high while an accepted phase is being served

Behaviour:
- Phase codes: 0 NONE, 1 E (e_str+e_left), 2 W (w_str+w_left), 3 EW_STR (e_str+w_str), 4 EW_LEFT (e_left+w_left), 5 NS.
- Served mask per phase: E=00011, W=01100, EW_STR=00101, EW_LEFT=01010, NS=10000.
- Reset state: state IDLE, pending=0, all ages=0, grant_valid=0, grant_phase=0, serving=0, rr_ptr=4.
- Pending latch, every cycle: pending <= (pending & ~clr) | req.
  - clr = served mask in the cycle phase_done is accepted in SERVE; 0 otherwise.
  - Set wins over clear on the same bit.
- Age counters: one per bit. A counter increments, saturating at MAX_WAIT, while its pending bit is 1 and it is not in the active served mask. It clears to 0 whenever its pending bit clears. urgent[i] = (age[i]==MAX_WAIT).
- Eligibility, over candidate index k:
  - k0 EW_STR: p0&p2.
  - k1 EW_LEFT: p1&p3.
  - k2 E: p0|p1.
  - k3 W: p2|p3.
  - k4 NS: p4.
- Selection:
  - If any urgent bit, the lowest-index urgent bit wins: bits 0/1 -> E, bits 2/3 -> W, bit 4 -> NS.
  - Otherwise, the first eligible k searching from rr_ptr+1 upward, wrapping mod 5.
- FSM:
  - IDLE: if pending!=0, register the selected phase into grant_phase, go to OFFER. Otherwise stay, grant_phase=0.
  - OFFER: grant_valid=1. grant_phase is held stable regardless of pending or age changes. On grant_ready, go to SERVE and set rr_ptr to the k of the granted phase; an urgent-chosen E/W/NS maps to k2/k3/k4.
  - SERVE: serving=1, grant_valid=0, grant_phase held. On phase_done, apply clr, go to IDLE, grant_phase <= 0.
- Latency: req high on cycle N -> pending visible N+1 -> grant_valid high N+2. The minimum IDLE dwell between phases is 1 cycle.
- Ignored inputs: phase_done in IDLE/OFFER; grant_ready outside OFFER.
- Reset mid-operation from any state returns every register to its reset value on the next edge. Any in-flight grant is dropped silently.
- A request dropping before service is not lost; it stays latched.

Decomposition:
- Package traffic_pkg holds:
  - phase_e enum (3-bit codes above);
  - req bit index constants (REQ_E_STR..REQ_NS);
  - served-mask function phase_mask(phase_e).
- One sub-module, phase_age_ctr: a single saturating age counter with inc/clr inputs and an urgent output, instantiated 5x.
- Selection logic and FSM live in the top module.

Test Plan:
- Reset, req=00001 pulsed for cycle 2 -> pending=00001 at cycle 3; grant_valid=1, grant_phase=1 (E) at cycle 4; ready then done -> pending=0, back to IDLE.
- req=11111 pulsed for one cycle, grant_ready tied 1, phase_done 3 cycles after each accept -> grants in order 3 (EW_STR), 4 (EW_LEFT), 5 (NS), then idle with pending=0.
- Offer of phase 5 with grant_ready low for 3 cycles while req toggles -> grant_valid stays 1 and grant_phase stays 5 throughout; accept on cycle 4.
- MAX_WAIT=4:
  - Pulse req=00100 and serve W (rr_ptr=3).
  - During SERVE, pulse req=10010.
  - Hold phase_done low 6 cycles.
  - Expected: next grant 1 (E, urgent e_left), then 5 (NS).
- While E is served, phase_done coincides with req=00001 -> pending=00001 (bit0 set wins, bit1 cleared); next grant_phase=1.
- Reset asserted for one cycle in SERVE with pending=10000 -> next cycle grant_valid=0, serving=0, pending=0, grant_phase=0; a subsequent req=10000 gets grant 5 with 2-cycle latency.
